// File: rtl/id_ex_stage.sv
//==============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use bubble insertion, stall and
//            flush handling, and a saturating hazard-bubble counter.
//            Hazard detection and the counter are present only when the
//            HAZARD_DETECT_EN macro is defined.
// Revision : 1.0
//==============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic              id_regWrite,
  input  logic              id_regDst,
  input  logic              id_ALUSrc,
  input  logic              id_branch,
  input  logic              id_memWrite,
  input  logic              id_memToReg,
  input  logic              id_memRead,
  input  logic              id_jump,
  input  logic [3:0]        id_ALUCntrl,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_regWrite,
  output logic              ex_regDst,
  output logic              ex_ALUSrc,
  output logic              ex_branch,
  output logic              ex_memWrite,
  output logic              ex_memToReg,
  output logic              ex_memRead,
  output logic              ex_jump,
  output logic [3:0]        ex_ALUCntrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              id_hold,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int WORD_W = 1 + 8 + 4 + 4 * DATA_W + 3 * REG_AW;

  logic [WORD_W-1:0] id_word;
  logic [WORD_W-1:0] ex_word_d;
  logic [WORD_W-1:0] ex_word_q;
  logic              hazard;

  // The whole execute slot travels as one vector so bubble/hold/load stay uniform.
  assign id_word = {id_valid, id_regWrite, id_regDst, id_ALUSrc, id_branch,
                    id_memWrite, id_memToReg, id_memRead, id_jump, id_ALUCntrl,
                    id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd};

  assign {ex_valid, ex_regWrite, ex_regDst, ex_ALUSrc, ex_branch,
          ex_memWrite, ex_memToReg, ex_memRead, ex_jump, ex_ALUCntrl,
          ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd} = ex_word_q;

`ifdef HAZARD_DETECT_EN
  logic             uses_rt;
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;

  assign uses_rt = id_regDst | id_memWrite | id_branch;
  assign hazard  = ex_valid & ex_memRead & (ex_rt != '0) & id_valid &
                   ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

  // Only hazard bubbles are counted; flush and stall take priority over them.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!flush && !ex_stall && hazard && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign hazard     = 1'b0;
  assign bubble_cnt = '0;
`endif

  // A squashed decode slot cannot hazard, so flush masks the hazard term.
  assign id_hold = flush ? ex_stall : (ex_stall | hazard);

  always_comb begin
    ex_word_d = ex_word_q;
    if (flush) begin
      ex_word_d = '0;
    end else if (ex_stall) begin
      ex_word_d = ex_word_q;
    end else if (hazard || !id_valid) begin
      ex_word_d = '0;
    end else begin
      ex_word_d = id_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_word_q <= '0;
    end else begin
      ex_word_q <= ex_word_d;
    end
  end

endmodule

`default_nettype wire
